// File: rtl/led_fade_pwm.sv
// Per-LED PWM display stage: asserted input bits light their LED at full
// brightness, deasserted bits fade out in fixed steps on a prescaled tick.
module led_fade_pwm #(
  parameter int unsigned N_LED     = 8,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned FADE_DIV  = 390625,
  parameter int unsigned FADE_STEP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_LED-1:0] in_bits,
  output logic [N_LED-1:0] led,
  output logic             fade_tick
);

  localparam int unsigned FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] BR_MAX   = '1;
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(FADE_STEP);
  localparam logic [FW-1:0]       DIV_LAST = FW'(FADE_DIV - 1);

  logic [N_LED-1:0]               s_meta;
  logic [N_LED-1:0]               s_bits;
  logic [PWM_BITS-1:0]            pwm_cnt;
  logic [FW-1:0]                  fade_cnt;
  logic [N_LED-1:0][PWM_BITS-1:0] br;
  logic [N_LED-1:0][PWM_BITS-1:0] br_nxt;
  logic [N_LED-1:0]               led_nxt;

  // Two-flop level synchroniser for the asynchronous counter bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_meta <= '0;
      s_bits <= '0;
    end else begin
      s_meta <= in_bits;
      s_bits <= s_meta;
    end
  end

  // Free-running PWM ramp and fade prescaler; both ignore en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt   <= '0;
      fade_cnt  <= '0;
      fade_tick <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      fade_cnt  <= (fade_cnt == DIV_LAST) ? '0 : fade_cnt + FW'(1);
      fade_tick <= (fade_cnt == DIV_LAST);
    end
  end

  // Set beats fade; fade saturates at zero
  always_comb begin
    br_nxt  = br;
    led_nxt = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      led_nxt[i] = en & (br[i] > pwm_cnt);
      if (s_bits[i]) begin
        br_nxt[i] = BR_MAX;
      end else if (fade_tick) begin
        br_nxt[i] = (br[i] > STEP) ? br[i] - STEP : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br  <= '0;
      led <= '0;
    end else begin
      br  <= br_nxt;
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: edge-indexed behavioural model checked every cycle,
// plus directed duty-cycle, latency and tick-timing expectations.
module tb_led_fade_pwm;

  localparam int NL   = 8;
  localparam int DIV  = 1024;
  localparam int STEP = 64;
  localparam int PER  = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b1;
  logic [NL-1:0] in_bits = '0;
  logic [NL-1:0] led;
  logic          fade_tick;

  led_fade_pwm #(.N_LED(NL), .PWM_BITS(8), .FADE_DIV(DIV), .FADE_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .en(en), .in_bits(in_bits),
    .led(led), .fade_tick(fade_tick)
  );

  always #5 clk = ~clk;

  // Model: t = edges since reset release; inputs reach the brightness
  // decision two edges after they are sampled.
  int            t = 0;
  int            br_m [NL];
  logic [NL-1:0] in_q [$];
  logic [NL-1:0] exp_led = '0;
  logic          exp_tick = 1'b0;
  logic [NL-1:0] s_now;
  logic [NL-1:0] nl;

  initial begin
    foreach (br_m[i]) br_m[i] = 0;
    in_q = '{8'h00, 8'h00};
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0;
      foreach (br_m[i]) br_m[i] = 0;
      in_q = '{8'h00, 8'h00};
      exp_led = '0;
      exp_tick = 1'b0;
    end else begin
      s_now = in_q[0];
      for (int i = 0; i < NL; i++) nl[i] = en && (br_m[i] > (t % PER));
      for (int i = 0; i < NL; i++) begin
        if (s_now[i]) br_m[i] = PER - 1;
        else if (exp_tick) br_m[i] = (br_m[i] > STEP) ? br_m[i] - STEP : 0;
      end
      exp_led = nl;
      in_q.push_back(in_bits);
      void'(in_q.pop_front());
      t = t + 1;
      exp_tick = (t % DIV == 0);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s (t=%0d): got %0d, expected %0d", name, t, got, want);
    end
  endtask

  // Every wait goes through here so each cycle is compared to the model
  task automatic step();
    @(negedge clk);
    check("led_vs_model", int'(led), int'(exp_led));
    check("tick_vs_model", int'(fade_tick), int'(exp_tick));
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!fade_tick && k < DIV + 16);
    check("tick_timeout", int'(fade_tick), 1);
  endtask

  task automatic count_on(input int idx, input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      step();
      c += int'(led[idx]);
    end
  endtask

  task automatic step_to(input int target);
    int k;
    k = 0;
    while (t != target && k < 3 * DIV) begin
      step();
      k++;
    end
    check("step_to_timeout", t, target);
  endtask

  int first, lat, c, others;
  int fade_exp [5] = '{191, 127, 63, 0, 0};

  initial begin
    #1 reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reset release: first tick after exactly DIV edges
    first = -1;
    for (int k = 0; k < DIV + 50 && first < 0; k++) begin
      step();
      if (fade_tick) first = t;
    end
    check("first_tick_edge", first, 1024);

    // Full brightness on bit 0, latency measured from a tick-aligned change
    in_bits = 8'h01;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (led[0] && lat < 0) lat = k;
    end
    check("set_latency", lat, 4);
    wait_tick();
    step();
    c = 0;
    others = 0;
    for (int k = 0; k < PER; k++) begin
      step();
      c += int'(led[0]);
      others += $countones(led[7:1]);
    end
    check("full_on_cnt", c, 255);
    check("other_leds_off", others, 0);

    // Fade staircase on bit 0
    in_bits = 8'h00;
    for (int s = 0; s < 5; s++) begin
      wait_tick();
      step();
      count_on(0, PER, c);
      check("fade_on_cnt", c, fade_exp[s]);
    end

    // s_bits[3] rises on the same cycle fade_tick is high
    step_to(8190);
    in_bits = 8'h08;
    step_to(8192);
    check("tick_at_8192", int'(fade_tick), 1);
    step_to(8194);
    check("set_beats_fade", int'(led[3]), 1);

    // en low across two fade ticks
    in_bits = 8'h00;
    step_to(8196);
    en = 1'b0;
    step();
    check("en_off_next_edge", int'(led), 0);
    repeat (2047) step();
    en = 1'b1;
    count_on(3, PER, c);
    check("duty_after_en", c, 127);

    // Asynchronous reset in the middle of a cycle during a fade
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_tick", int'(fade_tick), 0);
    repeat (3) step();
    reset = 1'b0;
    c = 0;
    first = -1;
    for (int k = 0; k < 3000; k++) begin
      step();
      c += $countones(led);
      if (fade_tick && first < 0) first = t;
    end
    check("dark_after_reset", c, 0);
    check("first_tick_after_rst", first, 1024);

    in_bits = 8'h80;
    repeat (4) step();
    count_on(7, PER, c);
    check("relit_led7", c, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
